// File: rtl/core_pkg.sv
// Shared types and constants for the instruction fetch front end.
package core_pkg;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    WAIT_GNT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/prefetch_fifo.sv
// Small circular FIFO holding fetched instructions; the head is read straight
// from the storage registers, so a pushed entry is visible one cycle later.
module prefetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             pushData,
  output fetch_entry_t             headData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t      mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic              doPush;
  logic              doPop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign doPush   = push && (!full || pop) && !flush;
  assign doPop    = pop && !empty && !flush;
  assign headData = mem[rdPtr];

  // Storage write; no reset needed, contents are only observed while valid.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointer and occupancy tracking; flush empties the queue at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: issues word fetches over a req/gnt/rvalid bus,
// buffers responses with their PC and presents one instruction per cycle.
// Handles Execute redirects by flushing and discarding stale responses.
// Optional: define PREFETCH_STATS_EN to add fetched/discarded counters.
module fetch_prefetch_buffer
  import core_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        instr_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched_o,
  output logic [31:0] stat_discarded_o
`endif
);

  localparam int unsigned FIFO_CW = $clog2(DEPTH) + 1;
  // Wide enough for stale responses piling up across back-to-back redirects.
  localparam int unsigned OUT_W   = 16;

  fetch_state_t        state;
  fetch_state_t        stateNext;
  logic [31:0]         fetchPc;
  logic [31:0]         heldAddr;
  logic [31:0]         rspPc;
  logic [31:0]         targetPc;
  logic                doomed;
  logic [OUT_W-1:0]    outstanding;
  logic [OUT_W-1:0]    discardCnt;
  logic [OUT_W-1:0]    inUse;
  logic                creditOk;
  logic                grantFire;
  logic                grantStale;
  logic                rspDrop;
  logic                rspKeep;
  logic                fifoPop;
  logic                fifoFull;
  logic                fifoEmpty;
  logic [FIFO_CW-1:0]  fifoCount;
  fetch_entry_t        pushEntry;
  fetch_entry_t        headEntry;

  assign targetPc   = redirect_pc_i & ~32'h0000_0003;
  assign inUse      = OUT_W'(fifoCount) + outstanding;
  assign creditOk   = !fifoFull && (inUse < OUT_W'(DEPTH)) &&
                      (outstanding < OUT_W'(MAX_OUTST));
  assign grantFire  = imem_req_o && imem_gnt_i;
  // A grant is stale if a redirect lands with it or hit its held request earlier.
  assign grantStale = grantFire && (redirect_i || ((state == WAIT_GNT) && doomed));
  assign rspDrop    = imem_rvalid_i && (redirect_i || (discardCnt != '0));
  assign rspKeep    = imem_rvalid_i && !rspDrop;
  assign fifoPop    = instr_valid_o && instr_ready_i;
  assign pushEntry  = '{instr: imem_rdata_i, pc: rspPc};

  // FSM state register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= BOOT;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      BOOT:     stateNext = FETCH;
      FETCH:    if (imem_req_o && !imem_gnt_i) stateNext = WAIT_GNT;
      WAIT_GNT: if (imem_gnt_i) stateNext = FETCH;
      default:  stateNext = BOOT;
    endcase
  end

  // FSM outputs: request whenever credit allows; a waiting request is held.
  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = fetchPc;
    case (state)
      FETCH: begin
        imem_req_o = creditOk;
      end
      WAIT_GNT: begin
        imem_req_o  = 1'b1;
        imem_addr_o = heldAddr;
      end
      default: begin
        imem_req_o = 1'b0;
      end
    endcase
  end

  // Held-request bookkeeping: remember its address and whether a redirect doomed it.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      heldAddr <= '0;
      doomed   <= 1'b0;
    end else if ((state == FETCH) && imem_req_o && !imem_gnt_i) begin
      heldAddr <= fetchPc;
      doomed   <= redirect_i;
    end else if (state == WAIT_GNT) begin
      if (imem_gnt_i) begin
        doomed <= 1'b0;
      end else if (redirect_i) begin
        doomed <= 1'b1;
      end
    end
  end

  // Fetch/response PCs and in-flight accounting; redirect overrides all else.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fetchPc     <= RESET_PC;
      rspPc       <= RESET_PC;
      outstanding <= '0;
      discardCnt  <= '0;
    end else if (redirect_i) begin
      fetchPc     <= targetPc;
      rspPc       <= targetPc;
      outstanding <= '0;
      discardCnt  <= discardCnt + outstanding + OUT_W'(grantFire) - OUT_W'(imem_rvalid_i);
    end else begin
      if (grantFire && !grantStale) begin
        fetchPc <= fetchPc + PC_INC;
      end
      if (rspKeep) begin
        rspPc <= rspPc + PC_INC;
      end
      outstanding <= outstanding + OUT_W'(grantFire && !grantStale) - OUT_W'(rspKeep);
      discardCnt  <= discardCnt + OUT_W'(grantStale) - OUT_W'(rspDrop);
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst_n),
    .push     (rspKeep),
    .pop      (fifoPop),
    .flush    (redirect_i),
    .pushData (pushEntry),
    .headData (headEntry),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // Head presentation; fields read as zero while nothing is valid.
  always_comb begin
    instr_valid_o = !fifoEmpty;
    instr_o       = '0;
    pc_o          = '0;
    pc_plus4_o    = '0;
    if (!fifoEmpty) begin
      instr_o    = headEntry.instr;
      pc_o       = headEntry.pc;
      pc_plus4_o = headEntry.pc + PC_INC;
    end
  end

`ifdef PREFETCH_STATS_EN
  // Wrapping counters of responses pushed and responses dropped.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      stat_fetched_o   <= '0;
      stat_discarded_o <= '0;
    end else begin
      stat_fetched_o   <= stat_fetched_o + 32'(rspKeep);
      stat_discarded_o <= stat_discarded_o + 32'(rspDrop);
    end
  end
`endif

endmodule

// File: doc/fetch_prefetch_buffer.md
Name: fetch_prefetch_buffer

Overview:
- Instruction-side front end that feeds the pipeline's fetch/decode boundary.
- Issues word fetches to the instruction memory bus over a req/gnt/rvalid handshake and buffers returned words with their PC in a small FIFO.
- Presents one instruction per cycle with PC and PC+4, in place of a direct combinational instruction-memory read.
- Handles branch/jump redirects from Execute (PCSrcE/PCTargetE) and fetch stalls (StallF) without losing or duplicating instructions.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- MAX_OUTST, 2: maximum granted-but-unreturned bus requests; 1 to DEPTH.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-high reset. The port keeps the codebase name; asserted = 1.
- redirect_i  in  1  taken branch/jump from Execute (PCSrcE).
- redirect_pc_i  in  32  redirect target (PCTargetE); bits [1:0] ignored.
- instr_ready_i  in  1  downstream accepts the head entry (driven as !StallF).
- instr_valid_o  out  1  head entry valid.
- instr_o  out  32  head instruction.
- pc_o  out  32  PC of the head instruction.
- pc_plus4_o  out  32  pc_o + 4, mod 2^32.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  word-aligned fetch address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid; responses return in order, at least 1 cycle after gnt.
- imem_rdata_i  in  32  read data.

Behaviour:
- Reset (asynchronous, while rst_n=1):
  - imem_req_o=0, instr_valid_o=0, instr_o=0, pc_o=0, pc_plus4_o=0.
  - fetch_pc=RESET_PC; FIFO empty; outstanding and discard counters = 0; FSM in BOOT.
- FSM states:
  - BOOT: one cycle after reset release, then -> FETCH.
  - FETCH: imem_req_o=1 with imem_addr_o=fetch_pc when credit>0, where credit = DEPTH - fifo_count - outstanding. Also requires outstanding < MAX_OUTST.
  - WAIT_GNT: entered when req=1 and gnt=0. req and addr are held unchanged until gnt; a redirect never retracts a pending request.
  - On gnt: fetch_pc += 4, outstanding++. Go to FETCH, or stay requesting back-to-back if credit remains.
- Responses:
  - rvalid with discard_cnt>0: decrement discard_cnt, drop the data.
  - Otherwise push {rdata, pc} into the FIFO; outstanding--.
  - The PC of each pushed entry comes from a response-PC register that advances by 4 per accepted response.
- Output:
  - The FIFO head is registered; a response appears on instr_valid_o no earlier than the cycle after rvalid (no bypass).
  - The head is popped when instr_valid_o && instr_ready_i.
  - Push and pop in the same cycle on a full FIFO is legal; count is unchanged.
- Redirect (takes priority over everything in the same cycle):
  - FIFO is flushed; instr_valid_o=0 next cycle.
  - discard_cnt += outstanding, plus 1 if gnt arrives in this same cycle. outstanding is cleared.
  - fetch_pc and response PC are set to {redirect_pc_i[31:2], 2'b00}.
  - If in WAIT_GNT, the held request completes at its old address, its response is discarded, then fetching resumes at the target.
  - The response arriving in the redirect cycle is discarded.
  - A redirect concurrent with a pop has no effect beyond the flush.
- Invariants:
  - fifo_count + outstanding <= DEPTH at all times.
  - Discarded responses do not consume FIFO slots.
  - instr_valid_o and the head fields remain stable while instr_ready_i=0.
- Mid-operation reset clears all state asynchronously. In-flight bus responses after reset release are the memory's responsibility; the bench re-resets the memory model.

Optional Feature:
- PREFETCH_STATS_EN:
  - When defined, adds output ports stat_fetched_o[31:0] (responses pushed) and stat_discarded_o[31:0] (responses dropped).
  - Both are wrapping counters, reset to 0.
  - When undefined, the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- core_pkg holds:
  - typedef fetch_entry_t {logic [31:0] instr; logic [31:0] pc;}
  - typedef enum fetch_state_t {BOOT, FETCH, WAIT_GNT}
  - constant NOP_INSTR = 32'h0000_0013
  - constant PC_INC = 32'd4
- Sub-module prefetch_fifo: parameterised DEPTH, element type fetch_entry_t, with push/pop/flush, full/empty and count outputs. All counter and FSM logic stays in the parent.

Test Plan:
- Reset release, gnt always 1, rvalid 1 cycle after gnt, ready=1 -> first fetch addr 0x0; instr_valid_o high 3 cycles after reset release; PCs 0x0,0x4,0x8,... one per cycle; pc_plus4_o = pc_o+4.
- ready=0 for 10 cycles -> at most DEPTH=4 entries buffered; no request while credit=0; head stays 0x0 stable; on ready=1 drains 0x0..0xC in order with no gaps or duplicates.
- Redirect to 0x100 with 2 outstanding -> both stale responses dropped (stat_discarded_o=2 when PREFETCH_STATS_EN defined); next valid pc_o=0x100.
- gnt held 0 for 5 cycles, redirect to 0x200 during the wait -> addr stays 0x8 until gnt; that response is dropped; next request addr 0x200.
- Redirect to 0x203 -> fetch address 0x200.
- Random gnt/rvalid delays plus random redirects over 10k cycles, scoreboarded against a golden PC model -> exact instruction/PC sequence, no overflow, invariant fifo_count+outstanding<=4 always holds.
- Assert rst_n mid-burst -> outputs 0 in the same cycle; after release, fetching restarts at RESET_PC.
